// File: rtl/debounce_pkg.sv
// Shared encodings for the debounce controller: FSM states and event codes.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        CHK_HI  = 2'd1,
        HELD_HI = 2'd2,
        CHK_LO  = 2'd3
    } state_t;

    localparam logic [1:0] EVT_PRESS   = 2'b01;
    localparam logic [1:0] EVT_RELEASE = 2'b10;
    localparam logic [1:0] EVT_LONG    = 2'b11;

endpackage

// File: rtl/async.sv
// Plain N_DFF-stage synchronizer for one asynchronous bit; deliberately not reset.
module async #(
    parameter int N_DFF = 3
) (
    input  logic clk,
    input  logic d_i,
    output logic q_o
);

    logic [N_DFF-1:0] sync_q;

    always_ff @(posedge clk) begin
        sync_q <= {sync_q[N_DFF-2:0], d_i};
    end

    assign q_o = sync_q[N_DFF-1];

endmodule

// File: rtl/evt_buf1.sv
// One-entry event buffer with valid/ready handshake; a post that finds the
// entry occupied and not being accepted is dropped and flagged by overrun_o.
module evt_buf1 #(
    parameter int CODE_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              post_i,
    input  logic [CODE_W-1:0] code_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [CODE_W-1:0] code_o,
    output logic              overrun_o
);

    logic              valid_q, valid_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              overrun_q, overrun_d;
    logic              accept;

    assign accept = valid_q && ready_i;

    always_comb begin
        valid_d   = valid_q;
        code_d    = code_q;
        overrun_d = 1'b0;
        if (post_i) begin
            // An accept on the same edge frees the slot for the new event.
            if (!valid_q || accept) begin
                valid_d = 1'b1;
                code_d  = code_i;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            code_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            code_q    <= code_d;
            overrun_q <= overrun_d;
        end
    end

    assign valid_o   = valid_q;
    assign code_o    = code_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/debounce_ctrl.sv
// Debounce and event controller for one mechanical input. Define
// DEBOUNCE_LONG_PRESS_EN to build the hold counter and LONG event.
module debounce_ctrl
    import debounce_pkg::*;
#(
    parameter int N_DFF       = 3,
    parameter int CNT_W       = 16,
    parameter int DEBOUNCE    = 1000,
    parameter int LONG_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       async_in,
    output logic       level,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [1:0] evt_code,
    output logic       overrun
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    if ((DEBOUNCE < 2) || (DEBOUNCE > 2**CNT_W - 1)) begin : g_bad_debounce
        $error("debounce_ctrl: DEBOUNCE out of range");
    end
    if ((LONG_CYCLES < 2) || (LONG_CYCLES > 2**CNT_W - 1)) begin : g_bad_long
        $error("debounce_ctrl: LONG_CYCLES out of range");
    end

    logic             sync_in;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             post;
    logic [1:0]       post_code;

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYCLES - 1);
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             long_done_q, long_done_d;
`endif

    async #(.N_DFF(N_DFF)) u_sync (
        .clk (clk),
        .d_i (async_in),
        .q_o (sync_in)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        post      = 1'b0;
        post_code = EVT_PRESS;
`ifdef DEBOUNCE_LONG_PRESS_EN
        hold_d      = hold_q;
        long_done_d = long_done_q;
`endif
        case (state_q)
            IDLE_LO: begin
                if (sync_in) begin
                    state_d = CHK_HI;
                    cnt_d   = CNT_W'(1);
                end
            end
            CHK_HI: begin
                if (!sync_in) begin
                    state_d = IDLE_LO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = HELD_HI;
                    level_d   = 1'b1;
                    post      = 1'b1;
                    post_code = EVT_PRESS;
`ifdef DEBOUNCE_LONG_PRESS_EN
                    hold_d      = '0;
                    long_done_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD_HI: begin
                // The hold count freezes while a release is being confirmed.
                if (!sync_in) begin
                    state_d = CHK_LO;
                    cnt_d   = CNT_W'(1);
                end
`ifdef DEBOUNCE_LONG_PRESS_EN
                else if (!long_done_q) begin
                    if (hold_q == HOLD_LAST) begin
                        post        = 1'b1;
                        post_code   = EVT_LONG;
                        long_done_d = 1'b1;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
`endif
            end
            CHK_LO: begin
                if (sync_in) begin
                    state_d = HELD_HI;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE_LO;
                    level_d   = 1'b0;
                    post      = 1'b1;
                    post_code = EVT_RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE_LO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

`ifdef DEBOUNCE_LONG_PRESS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q      <= '0;
            long_done_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            long_done_q <= long_done_d;
        end
    end
`endif

    evt_buf1 #(.CODE_W(2)) u_evt (
        .clk       (clk),
        .rst       (rst),
        .post_i    (post),
        .code_i    (post_code),
        .ready_i   (evt_ready),
        .valid_o   (evt_valid),
        .code_o    (evt_code),
        .overrun_o (overrun)
    );

    assign level = level_q;

endmodule

// File: tb/tb_debounce_ctrl.sv
// Bench for debounce_ctrl with N_DFF=3, DEBOUNCE=4, LONG_CYCLES=10.
module tb_debounce_ctrl;

    localparam logic [1:0] C_NONE    = 2'b00;
    localparam logic [1:0] C_PRESS   = 2'b01;
    localparam logic [1:0] C_RELEASE = 2'b10;
    localparam logic [1:0] C_LONG    = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       async_in = 1'b0;
    logic       evt_ready = 1'b1;
    logic       level;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic       overrun;

    int checks = 0;
    int failures = 0;

    logic       mon_en = 1'b0;
    int         ovr_cnt = 0;
    logic [1:0] exp_q[$];
    logic [1:0] mon_exp;

    typedef struct {
        int         runs[6];
        int         n_evt;
        logic [1:0] codes[3];
        logic       fin_level;
    } vec_t;

    vec_t vecs[5];

    debounce_ctrl #(
        .N_DFF       (3),
        .CNT_W       (16),
        .DEBOUNCE    (4),
        .LONG_CYCLES (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .async_in  (async_in),
        .level     (level),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int i, input int r0, input int r1, input int r2,
                           input int r3, input int r4, input int r5, input int n,
                           input logic [1:0] c0, input logic [1:0] c1,
                           input logic [1:0] c2, input logic fl);
        vecs[i].runs[0] = r0; vecs[i].runs[1] = r1; vecs[i].runs[2] = r2;
        vecs[i].runs[3] = r3; vecs[i].runs[4] = r4; vecs[i].runs[5] = r5;
        vecs[i].n_evt = n;
        vecs[i].codes[0] = c0; vecs[i].codes[1] = c1; vecs[i].codes[2] = c2;
        vecs[i].fin_level = fl;
    endtask

    // Scoreboard: every accepted event is popped and compared in order.
    always @(negedge clk) begin
        if (mon_en) begin
            if (overrun) ovr_cnt++;
            if (evt_valid && evt_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL evt_unexpected actual=%b required=none", evt_code);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (evt_code !== mon_exp) begin
                        failures++;
                        $display("FAIL evt_code actual=%b required=%b", evt_code, mon_exp);
                    end
                end
            end
        end
    end

    initial begin
        int ov;

        // Vector table: alternating run lengths starting high, expected events.
`ifdef DEBOUNCE_LONG_PRESS_EN
        set_vec(0, 20, 12, 0, 0, 0, 0, 3, C_PRESS, C_LONG, C_RELEASE, 1'b0);
        set_vec(4, 30, 1, 5, 12, 0, 0, 3, C_PRESS, C_LONG, C_RELEASE, 1'b0);
`else
        set_vec(0, 20, 12, 0, 0, 0, 0, 2, C_PRESS, C_RELEASE, C_NONE, 1'b0);
        set_vec(4, 30, 1, 5, 12, 0, 0, 2, C_PRESS, C_RELEASE, C_NONE, 1'b0);
`endif
        set_vec(1, 3, 12, 0, 0, 0, 0, 0, C_NONE, C_NONE, C_NONE, 1'b0);
        set_vec(2, 4, 12, 0, 0, 0, 0, 2, C_PRESS, C_RELEASE, C_NONE, 1'b0);
        set_vec(3, 12, 1, 1, 1, 1, 12, 2, C_PRESS, C_RELEASE, C_NONE, 1'b0);

        // Reset state
        #1 rst = 1'b1;
        cyc(5);
        chk("rst_level", level, 1'b0);
        chk("rst_valid", evt_valid, 1'b0);
        chk("rst_code", evt_code, C_NONE);
        chk("rst_overrun", overrun, 1'b0);
        rst = 1'b0;
        cyc(2);

        // Table-driven scenarios
        mon_en = 1'b1;
        evt_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            ovr_cnt = 0;
            for (int e = 0; e < vecs[v].n_evt; e++) exp_q.push_back(vecs[v].codes[e]);
            for (int r = 0; r < 6; r++) begin
                for (int k = 0; k < vecs[v].runs[r]; k++) begin
                    async_in = (r % 2 == 0);
                    cyc(1);
                end
            end
            chk($sformatf("vec%0d_pending", v), exp_q.size(), 0);
            chk($sformatf("vec%0d_level", v), level, vecs[v].fin_level);
            chk($sformatf("vec%0d_overrun", v), ovr_cnt, 0);
            exp_q.delete();
        end
        mon_en = 1'b0;

        // Reset in CHK_HI, then in HELD_HI with a PRESS pending
        evt_ready = 1'b0;
        async_in = 1'b1;
        cyc(5);
        rst = 1'b1;
        #1;
        chk("rstchk_level", level, 1'b0);
        chk("rstchk_valid", evt_valid, 1'b0);
        async_in = 1'b0;
        cyc(4);
        rst = 1'b0;
        cyc(10);
        chk("rstchk_quiet_level", level, 1'b0);
        chk("rstchk_quiet_valid", evt_valid, 1'b0);
        async_in = 1'b1;
        cyc(9);
        chk("held_level", level, 1'b1);
        chk("held_valid", evt_valid, 1'b1);
        chk("held_code", evt_code, C_PRESS);
        rst = 1'b1;
        #1;
        chk("rsthld_level", level, 1'b0);
        chk("rsthld_valid", evt_valid, 1'b0);
        chk("rsthld_code", evt_code, C_NONE);
        async_in = 1'b0;
        cyc(4);
        rst = 1'b0;
        evt_ready = 1'b1;
        cyc(12);
        chk("rsthld_no_release", evt_valid, 1'b0);
        chk("rsthld_quiet_level", level, 1'b0);

        // Clean press: exact latency, single-cycle valid, LONG timing
        async_in = 1'b1;
        cyc(6);
        chk("press_early_level", level, 1'b0);
        cyc(1);
        chk("press_level", level, 1'b1);
        chk("press_valid", evt_valid, 1'b1);
        chk("press_code", evt_code, C_PRESS);
        cyc(1);
        chk("press_single_cycle", evt_valid, 1'b0);
        cyc(8);
        chk("long_early_valid", evt_valid, 1'b0);
        cyc(1);
`ifdef DEBOUNCE_LONG_PRESS_EN
        chk("long_valid", evt_valid, 1'b1);
        chk("long_code", evt_code, C_LONG);
`else
        chk("nolong_valid", evt_valid, 1'b0);
`endif
        ov = 0;
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            if (evt_valid) ov++;
        end
        chk("long_once", ov, 0);
        async_in = 1'b0;
        cyc(12);
        chk("clean_release_level", level, 1'b0);

        // Overrun: consumer stalled through press and release
        evt_ready = 1'b0;
        ov = 0;
        for (int k = 0; k < 24; k++) begin
            async_in = (k < 8);
            cyc(1);
            if (overrun) ov++;
        end
        chk("ovr_pulses", ov, 1);
        chk("ovr_valid", evt_valid, 1'b1);
        chk("ovr_code_held", evt_code, C_PRESS);
        chk("ovr_level", level, 1'b0);
        evt_ready = 1'b1;
        cyc(1);
        chk("ovr_drained", evt_valid, 1'b0);
        cyc(3);
        chk("ovr_nothing_left", evt_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
